// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit.
// Encodings 5-7 of pc_op_t are reserved and are executed as PC_SEQ.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_GOTO   = 3'd2,
        PC_CALL   = 3'd3,
        PC_RET    = 3'd4
    } pc_op_t;

endpackage

// File: rtl/return_stack.sv
// Parametrised LIFO of return addresses; pushes when full and pops when empty are dropped.
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    count;
    logic [DW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top_idx = count - DW'(1);
    assign top     = mem[top_idx[AW-1:0]];
    assign depth   = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + DW'(1);
        end else if (do_pop) begin
            count <= count - DW'(1);
        end
    end

    // Entries need no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[count[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential advance, relative branch, absolute jump and call/return.
// Any stack overflow or underflow freezes the unit until reset.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned        PC_WIDTH     = 16,
    parameter int unsigned        ARGC_WIDTH   = 2,
    parameter int unsigned        OFFSET_WIDTH = 16,
    parameter int unsigned        STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             op_done,
    input  logic [ARGC_WIDTH-1:0]            argc,
    input  pc_op_t                           pc_op,
    input  logic                             cond,
    input  logic [OFFSET_WIDTH-1:0]          offset,
    input  logic [PC_WIDTH-1:0]              target,
    output logic [PC_WIDTH-1:0]              pc,
    output logic                             redirect,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             fault
);

    logic [PC_WIDTH-1:0] seq_next;
    logic [PC_WIDTH-1:0] rel_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] stack_top;
    logic                push;
    logic                pop;
    logic                redirect_next;
    logic                fault_set;

    assign seq_next = pc + PC_WIDTH'(argc) + PC_WIDTH'(1);
    assign rel_next = pc + PC_WIDTH'($signed(offset));

    always_comb begin
        pc_next       = pc;
        push          = 1'b0;
        pop           = 1'b0;
        redirect_next = 1'b0;
        fault_set     = 1'b0;
        if (op_done && !fault) begin
            case (pc_op)
                PC_BRANCH: begin
                    pc_next       = cond ? rel_next : seq_next;
                    redirect_next = cond;
                end
                PC_GOTO: begin
                    pc_next       = target;
                    redirect_next = 1'b1;
                end
                PC_CALL: begin
                    if (stack_full) begin
                        fault_set = 1'b1;
                    end else begin
                        push          = 1'b1;
                        pc_next       = rel_next;
                        redirect_next = 1'b1;
                    end
                end
                PC_RET: begin
                    if (stack_empty) begin
                        fault_set = 1'b1;
                    end else begin
                        pop           = 1'b1;
                        pc_next       = stack_top;
                        redirect_next = 1'b1;
                    end
                end
                default: pc_next = seq_next;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
            fault    <= 1'b0;
        end else begin
            pc       <= pc_next;
            redirect <= redirect_next;
            fault    <= fault | fault_set;
        end
    end

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (seq_next),
        .top       (stack_top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_done;
    logic [1:0]  argc;
    pc_op_t      pc_op;
    logic        cond;
    logic [15:0] offset;
    logic [15:0] target;
    logic [15:0] pc;
    logic        redirect;
    logic [2:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        fault;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_WIDTH     (16),
        .ARGC_WIDTH   (2),
        .OFFSET_WIDTH (16),
        .STACK_DEPTH  (4),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_done     (op_done),
        .argc        (argc),
        .pc_op       (pc_op),
        .cond        (cond),
        .offset      (offset),
        .target      (target),
        .pc          (pc),
        .redirect    (redirect),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .fault       (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input pc_op_t op, input logic [1:0] a, input logic c,
                        input logic [15:0] off, input logic [15:0] tgt);
        pc_op   = op;
        argc    = a;
        cond    = c;
        offset  = off;
        target  = tgt;
        op_done = 1'b1;
        @(posedge clk);
        #1;
        op_done = 1'b0;
    endtask

    task automatic idle();
        op_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        op_done = 1'b0;
        argc    = '0;
        pc_op   = PC_SEQ;
        cond    = 1'b0;
        offset  = '0;
        target  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_redirect", redirect, 0);
        chk("reset_depth", depth, 0);
        chk("reset_empty", stack_empty, 1);
        chk("reset_full", stack_full, 0);
        chk("reset_fault", fault, 0);
        rst_n = 1'b1;

        // Sequential advance
        step(PC_SEQ, 2'd0, 1'b0, 16'h0, 16'h0);
        chk("seq_a0", pc, 16'h0001);
        step(PC_SEQ, 2'd2, 1'b0, 16'h0, 16'h0);
        chk("seq_a2", pc, 16'h0004);
        step(PC_SEQ, 2'd1, 1'b0, 16'h0, 16'h0);
        chk("seq_a1", pc, 16'h0006);
        chk("seq_redirect", redirect, 0);

        // Stall ignores a GOTO on the inputs
        pc_op  = PC_GOTO;
        target = 16'h5555;
        idle();
        chk("stall_pc", pc, 16'h0006);

        // Taken and not-taken branch
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'h0010);
        chk("goto_pc", pc, 16'h0010);
        chk("goto_redirect", redirect, 1);
        idle();
        chk("redirect_one_cycle", redirect, 0);
        step(PC_BRANCH, 2'd0, 1'b1, 16'hFFFC, 16'h0);
        chk("br_taken_pc", pc, 16'h000C);
        chk("br_taken_redirect", redirect, 1);
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'h0010);
        step(PC_BRANCH, 2'd2, 1'b0, 16'hFFFC, 16'h0);
        chk("br_nt_pc", pc, 16'h0013);
        chk("br_nt_redirect", redirect, 0);

        // Wrap-around
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'hFFFE);
        chk("goto_top_pc", pc, 16'hFFFE);
        step(PC_SEQ, 2'd2, 1'b0, 16'h0, 16'h0);
        chk("wrap_pc", pc, 16'h0001);

        // Reserved encoding behaves as SEQ
        step(pc_op_t'(3'd7), 2'd3, 1'b1, 16'h0, 16'h0);
        chk("reserved_pc", pc, 16'h0005);
        chk("reserved_redirect", redirect, 0);

        // Call and return
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'h0020);
        step(PC_CALL, 2'd2, 1'b0, 16'h0100, 16'h0);
        chk("call_pc", pc, 16'h0120);
        chk("call_depth", depth, 1);
        chk("call_redirect", redirect, 1);
        chk("call_empty", stack_empty, 0);
        step(PC_RET, 2'd0, 1'b0, 16'h0, 16'h0);
        chk("ret_pc", pc, 16'h0023);
        chk("ret_depth", depth, 0);
        chk("ret_empty", stack_empty, 1);
        chk("ret_redirect", redirect, 1);

        // Nested calls up to overflow
        step(PC_CALL, 2'd0, 1'b0, 16'h0010, 16'h0);
        chk("nest1_pc", pc, 16'h0033);
        step(PC_CALL, 2'd0, 1'b0, 16'h0010, 16'h0);
        step(PC_CALL, 2'd0, 1'b0, 16'h0010, 16'h0);
        chk("nest3_full", stack_full, 0);
        step(PC_CALL, 2'd0, 1'b0, 16'h0010, 16'h0);
        chk("nest4_pc", pc, 16'h0063);
        chk("nest4_depth", depth, 4);
        chk("nest4_full", stack_full, 1);
        chk("nest4_fault", fault, 0);
        step(PC_CALL, 2'd0, 1'b0, 16'h0010, 16'h0);
        chk("overflow_pc", pc, 16'h0063);
        chk("overflow_fault", fault, 1);
        chk("overflow_redirect", redirect, 0);
        chk("overflow_depth", depth, 4);
        step(PC_SEQ, 2'd1, 1'b0, 16'h0, 16'h0);
        chk("frozen_seq_pc", pc, 16'h0063);
        step(PC_RET, 2'd0, 1'b0, 16'h0, 16'h0);
        chk("frozen_ret_pc", pc, 16'h0063);
        chk("frozen_ret_depth", depth, 4);
        chk("frozen_fault", fault, 1);

        // Reset wins over a concurrent GOTO
        rst_n = 1'b0;
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'h1234);
        chk("rst1_pc", pc, 16'h0000);
        chk("rst1_fault", fault, 0);
        chk("rst1_depth", depth, 0);
        rst_n = 1'b1;

        // Underflow
        step(PC_SEQ, 2'd1, 1'b0, 16'h0, 16'h0);
        chk("pre_uf_pc", pc, 16'h0002);
        step(PC_RET, 2'd0, 1'b0, 16'h0, 16'h0);
        chk("underflow_pc", pc, 16'h0002);
        chk("underflow_fault", fault, 1);
        chk("underflow_redirect", redirect, 0);
        rst_n = 1'b0;
        step(PC_GOTO, 2'd0, 1'b0, 16'h0, 16'h4321);
        chk("rst2_pc", pc, 16'h0000);
        chk("rst2_fault", fault, 0);
        chk("rst2_depth", depth, 0);
        chk("rst2_empty", stack_empty, 1);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
